// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : 4-digit multiplexed seven-segment driver with shadow
//                    registers, refresh prescaler and inter-digit dead time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  segEn,
  output logic [6:0]  seg,
  output logic        segDec
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [15:0]   sh_val;
  logic [3:0]    sh_dp;
  logic [3:0]    sh_blank;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [3:0]    nib_zero;
  logic [3:0]    cur_nib;
  logic          suppress;
  logic          digit_off;
  logic [3:0]    next_en;
  logic [6:0]    next_seg;
  logic          next_dec;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_zero
    assign nib_zero[k] = (sh_val[4*k +: 4] == 4'h0);
  end

  always_comb begin
    cur_nib  = sh_val[{idx, 2'b00} +: 4];
    suppress = 1'b0;
    case (idx)
      2'd1:    suppress = &nib_zero[3:1];
      2'd2:    suppress = &nib_zero[3:2];
      2'd3:    suppress = nib_zero[3];
      default: suppress = 1'b0;
    endcase
    digit_off = sh_blank[idx] | (LZ_SUPPRESS & suppress);

    next_en  = 4'b1111;
    next_seg = 7'b1111111;
    next_dec = 1'b1;
    // cnt==0 is the dead cycle that separates consecutive digits
    if ((cnt != '0) && !digit_off) begin
      next_en  = ~(4'b0001 << idx);
      next_seg = hex_to_seg(cur_nib);
      next_dec = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      cnt      <= '0;
      idx      <= '0;
      segEn    <= 4'b1111;
      seg      <= 7'b1111111;
      segDec   <= 1'b1;
    end else begin
      if (load) begin
        sh_val   <= value;
        sh_dp    <= dp;
        sh_blank <= blank;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      segEn  <= next_en;
      seg    <= next_seg;
      segDec <= next_dec;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : directed self-checking bench, REFRESH_DIV=4, with one
//                       instance per leading-zero setting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic [3:0]  segEn, segEn_lz;
  logic [6:0]  seg, seg_lz;
  logic        segDec, segDec_lz;

  int checks = 0;
  int errors = 0;

  // Hand-entered decode table, gfedcba active-low
  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(.REFRESH_DIV(4), .LZ_SUPPRESS(1'b0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .segEn(segEn), .seg(seg), .segDec(segDec)
  );

  seg7_scan_driver #(.REFRESH_DIV(4), .LZ_SUPPRESS(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .segEn(segEn_lz), .seg(seg_lz), .segDec(segDec_lz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_en"}, segEn, 16'hF);
    check({tag, "_seg"}, seg, 16'h7F);
    check({tag, "_dec"}, segDec, 16'h1);
    check({tag, "_lz_en"}, segEn_lz, 16'hF);
    check({tag, "_lz_seg"}, seg_lz, 16'h7F);
  endtask

  // Reset, then release with a load; leaves the bench just after frame edge 1
  task automatic restart(input string tag, input logic [15:0] v,
                         input logic [3:0] dpv, input logic [3:0] bl);
    rst = 1'b1; load = 1'b0;
    tick();
    check_dark({tag, "_rst"});
    rst = 1'b0; load = 1'b1; value = v; dp = dpv; blank = bl;
    tick();
    load = 1'b0;
    check_dark({tag, "_e1"});
  endtask

  // Checks frame edges 2..16 against the digit pattern implied by v/dpv
  task automatic run_frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                           input logic [3:0] on, input logic [3:0] lz_on);
    for (int e = 2; e <= 16; e++) begin
      int d;
      int pos;
      logic [3:0] nib;
      logic [3:0] en_exp, en_lz_exp;
      logic [6:0] seg_exp, seg_lz_exp;
      logic       dec_exp;
      tick();
      d   = (e - 1) / 4;
      pos = (e - 1) % 4;
      nib = v[4*d +: 4];
      en_exp = 4'hF; seg_exp = 7'h7F; dec_exp = 1'b1;
      en_lz_exp = 4'hF; seg_lz_exp = 7'h7F;
      if (pos != 0 && on[d]) begin
        en_exp  = ~(4'b0001 << d);
        seg_exp = dec_tab[nib];
        dec_exp = ~dpv[d];
      end
      if (pos != 0 && lz_on[d]) begin
        en_lz_exp  = ~(4'b0001 << d);
        seg_lz_exp = dec_tab[nib];
      end
      check($sformatf("%s_e%0d_en", tag, e), segEn, en_exp);
      check($sformatf("%s_e%0d_seg", tag, e), seg, seg_exp);
      check($sformatf("%s_e%0d_dec", tag, e), segDec, dec_exp);
      check($sformatf("%s_e%0d_lz_en", tag, e), segEn_lz, en_lz_exp);
      check($sformatf("%s_e%0d_lz_seg", tag, e), seg_lz, seg_lz_exp);
      check($sformatf("%s_e%0d_onehot", tag, e), 16'($countones(~segEn) <= 1), 16'h1);
    end
  endtask

  initial begin
    // Scan order and basic digits
    restart("scan", 16'h1234, 4'b0000, 4'b0000);
    run_frame("scan", 16'h1234, 4'b0000, 4'b1111, 4'b1111);
    // Wrap back to digit 0 dead cycle
    tick();
    check("wrap_dead_en", segEn, 16'hF);
    tick();
    check("wrap_d0_en", segEn, 16'hE);

    // Full decode sweep
    restart("dec0", 16'h0123, 4'b0000, 4'b0000);
    run_frame("dec0", 16'h0123, 4'b0000, 4'b1111, 4'b0111);
    restart("dec1", 16'h4567, 4'b0000, 4'b0000);
    run_frame("dec1", 16'h4567, 4'b0000, 4'b1111, 4'b1111);
    restart("dec2", 16'h89AB, 4'b0000, 4'b0000);
    run_frame("dec2", 16'h89AB, 4'b0000, 4'b1111, 4'b1111);
    restart("dec3", 16'hCDEF, 4'b0000, 4'b0000);
    run_frame("dec3", 16'hCDEF, 4'b0000, 4'b1111, 4'b1111);

    // Decimal points and forced blank
    restart("dpbl", 16'hFFFF, 4'b0101, 4'b1000);
    run_frame("dpbl", 16'hFFFF, 4'b0101, 4'b0111, 4'b0111);

    // Leading zeros
    restart("lz50", 16'h0050, 4'b0000, 4'b0000);
    run_frame("lz50", 16'h0050, 4'b0000, 4'b1111, 4'b0011);
    restart("lz00", 16'h0000, 4'b0000, 4'b0000);
    run_frame("lz00", 16'h0000, 4'b0000, 4'b1111, 4'b0001);

    // Load mid-dwell: captured on edge 3, visible on edge 4
    restart("mid", 16'h0001, 4'b0000, 4'b0000);
    tick();
    check("mid_e2_seg", seg, 16'h79);
    load = 1'b1; value = 16'h0007;
    tick();
    load = 1'b0;
    check("mid_e3_seg", seg, 16'h79);
    check("mid_e3_en", segEn, 16'hE);
    tick();
    check("mid_e4_seg", seg, 16'h78);
    check("mid_e4_en", segEn, 16'hE);

    // Reset with load during digit 2
    restart("rp", 16'h1234, 4'b1111, 4'b0000);
    for (int i = 0; i < 9; i++) tick();
    check("rp_d2_en", segEn, 16'hB);
    check("rp_d2_seg", seg, 16'h24);
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp = 4'hF;
    tick();
    check_dark("rp_rst");
    rst = 1'b0; load = 1'b0;
    tick();
    check_dark("rp_e1");
    tick();
    check("rp_e2_en", segEn, 16'hE);
    check("rp_e2_seg", seg, 16'h40);
    check("rp_e2_dec", segDec, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
